// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control unit for a multicycle MIPS-style datapath. This is a Moore FSM
// with a single state register. Every datapath control strobe is decoded
// combinationally from the current state. The only exception is the FETCH
// write enables, which also follow the memory handshake.
//
// Parameters
//   MEM_HANDSHAKE : 1 = FETCH/MEMRD/MEMWR wait for mem_ready,
//                   0 = mem_ready is ignored (memory always completes).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset (forces state RST)
//   Op[5:0]      in   opcode field from the instruction register
//   mem_ready    in   memory completion handshake
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
//   IRWrite, ALUSrcA, RegWrite, RegDst            out  1-bit strobes/selects
//   ALUOp[1:0]   out  00 add, 01 sub, 10 funct decode
//   ALUSrcB[1:0] out  ALU B operand select
//   PCSource[1:0] out PC next-value select
//   state[3:0]   out  current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;

    // With the handshake disabled, every memory access completes in one cycle.
    logic mem_done;
    assign mem_done = (MEM_HANDSHAKE == 1'b0) || mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // IR and PC are only written once the instruction word is valid.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_done;
                PCWrite = mem_done;
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ALUSrcB = 2'b11;
                case (Op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;  // illegal opcode retires as a NOP
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_done) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                // Unused encodings recover through RST.
                state_d = S_RST;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       mem_ready;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] state;

    // Second instance with the handshake disabled
    logic       reset1;
    logic [5:0] Op1;
    logic       mem_ready1;
    logic       PCWrite1, PCWriteCond1, IorD1, MemRead1, MemWrite1, MemtoReg1;
    logic       IRWrite1, ALUSrcA1, RegWrite1, RegDst1;
    logic [1:0] ALUOp1, ALUSrcB1, PCSource1;
    logic [3:0] state1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .state(state)
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
        .clk(clk), .reset(reset1), .Op(Op1), .mem_ready(mem_ready1),
        .PCWrite(PCWrite1), .PCWriteCond(PCWriteCond1), .IorD(IorD1),
        .MemRead(MemRead1), .MemWrite(MemWrite1), .MemtoReg(MemtoReg1),
        .IRWrite(IRWrite1), .ALUSrcA(ALUSrcA1), .RegWrite(RegWrite1),
        .RegDst(RegDst1), .ALUOp(ALUOp1), .ALUSrcB(ALUSrcB1),
        .PCSource(PCSource1), .state(state1)
    );

    // Packed view of all control outputs:
    // [15]PCWrite [14]PCWriteCond [13]IorD [12]MemRead [11]MemWrite [10]MemtoReg
    // [9]IRWrite [8]ALUSrcA [7]RegWrite [6]RegDst [5:4]ALUOp [3:2]ALUSrcB [1:0]PCSource
    logic [15:0] outs, outs1;
    assign outs  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};
    assign outs1 = {PCWrite1, PCWriteCond1, IorD1, MemRead1, MemWrite1, MemtoReg1,
                    IRWrite1, ALUSrcA1, RegWrite1, RegDst1, ALUOp1, ALUSrcB1, PCSource1};

    // Hand-derived expected output words per state
    localparam logic [15:0] O_RST      = 16'h0000;
    localparam logic [15:0] O_FETCH    = 16'h9204;  // MemRead, IRWrite, PCWrite, ALUSrcB=01
    localparam logic [15:0] O_FETCH_WT = 16'h1004;  // MemRead, ALUSrcB=01, no writes
    localparam logic [15:0] O_DECODE   = 16'h000C;
    localparam logic [15:0] O_MEMADR   = 16'h0108;
    localparam logic [15:0] O_MEMRD    = 16'h3000;
    localparam logic [15:0] O_MEMWB    = 16'h0480;
    localparam logic [15:0] O_MEMWR    = 16'h2800;
    localparam logic [15:0] O_EXEC     = 16'h0120;
    localparam logic [15:0] O_ALUWB    = 16'h00C0;
    localparam logic [15:0] O_BRANCH   = 16'h4111;
    localparam logic [15:0] O_JUMP     = 16'h8002;
    localparam logic [15:0] O_ADDIEX   = 16'h0108;
    localparam logic [15:0] O_ADDIWB   = 16'h0080;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [15:0] exp_out);
        check({tag, ".state"}, {12'h000, state}, {12'h000, exp_st});
        check({tag, ".outs"}, outs, exp_out);
    endtask

    task automatic chk1(input string tag, input logic [3:0] exp_st, input logic [15:0] exp_out);
        check({tag, ".state"}, {12'h000, state1}, {12'h000, exp_st});
        check({tag, ".outs"}, outs1, exp_out);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Op = 6'b000000; mem_ready = 1'b1;
        reset1 = 1'b1; Op1 = 6'b101011; mem_ready1 = 1'b0;

        // Reset held across edges
        #2;
        chk("rst_async", 4'd0, O_RST);
        step();
        chk("rst_hold0", 4'd0, O_RST);
        step();
        chk("rst_hold1", 4'd0, O_RST);

        // R-type: 0,1,2,7,8,1
        reset = 1'b0;
        chk("rtype_rst", 4'd0, O_RST);
        step(); chk("rtype_fetch", 4'd1, O_FETCH);
        step(); chk("rtype_decode", 4'd2, O_DECODE);
        step(); chk("rtype_exec", 4'd7, O_EXEC);
        Op = 6'b100011;  // changing Op outside DECODE/MEMADR must not matter
        step(); chk("rtype_aluwb", 4'd8, O_ALUWB);
        step(); chk("rtype_fetch2", 4'd1, O_FETCH);

        // lw with 3 wait cycles in MEMRD
        step(); chk("lw_decode", 4'd2, O_DECODE);
        step(); chk("lw_memadr", 4'd3, O_MEMADR);
        mem_ready = 1'b0;
        step(); chk("lw_memrd0", 4'd4, O_MEMRD);
        step(); chk("lw_memrd1", 4'd4, O_MEMRD);
        step(); chk("lw_memrd2", 4'd4, O_MEMRD);
        step();
        mem_ready = 1'b1;
        #1;
        chk("lw_memrd3", 4'd4, O_MEMRD);
        step(); chk("lw_memwb", 4'd5, O_MEMWB);
        step(); chk("lw_fetch", 4'd1, O_FETCH);

        // FETCH stall while memory is not ready
        mem_ready = 1'b0;
        Op = 6'b000100;
        #1;
        chk("fetch_wait", 4'd1, O_FETCH_WT);
        step(); chk("fetch_wait_hold", 4'd1, O_FETCH_WT);
        mem_ready = 1'b1;

        // beq: one BRANCH cycle
        step(); chk("beq_decode", 4'd2, O_DECODE);
        step(); chk("beq_branch", 4'd9, O_BRANCH);
        step(); chk("beq_fetch", 4'd1, O_FETCH);

        // Illegal opcode: DECODE straight back to FETCH
        Op = 6'b111111;
        step(); chk("ill_decode", 4'd2, O_DECODE);
        step(); chk("ill_fetch", 4'd1, O_FETCH);

        // j
        Op = 6'b000010;
        step(); chk("j_decode", 4'd2, O_DECODE);
        step(); chk("j_jump", 4'd10, O_JUMP);
        step(); chk("j_fetch", 4'd1, O_FETCH);

        // addi
        Op = 6'b001000;
        step(); chk("addi_decode", 4'd2, O_DECODE);
        step(); chk("addi_ex", 4'd11, O_ADDIEX);
        step(); chk("addi_wb", 4'd12, O_ADDIWB);
        step(); chk("addi_fetch", 4'd1, O_FETCH);

        // sw with reset mid MEMWR wait
        Op = 6'b101011;
        step(); chk("sw_decode", 4'd2, O_DECODE);
        step(); chk("sw_memadr", 4'd3, O_MEMADR);
        mem_ready = 1'b0;
        step(); chk("sw_memwr0", 4'd6, O_MEMWR);
        step(); chk("sw_memwr1", 4'd6, O_MEMWR);
        #2;
        reset = 1'b1;
        #1;
        chk("sw_async_rst", 4'd0, O_RST);
        step(); chk("sw_rst_hold", 4'd0, O_RST);
        reset = 1'b0;
        mem_ready = 1'b1;
        step(); chk("sw_after_rst", 4'd1, O_FETCH);

        // Handshake disabled: sw with mem_ready low runs 1,2,3,6,1
        reset1 = 1'b0;
        chk1("nohs_rst", 4'd0, O_RST);
        step(); chk1("nohs_fetch", 4'd1, O_FETCH);
        step(); chk1("nohs_decode", 4'd2, O_DECODE);
        step(); chk1("nohs_memadr", 4'd3, O_MEMADR);
        step(); chk1("nohs_memwr", 4'd6, O_MEMWR);
        step(); chk1("nohs_fetch2", 4'd1, O_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Op, input, 6 bits: instruction opcode field from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completion handshake.
REQ-006 SHALL have these 1-bit output ports: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-007 SHALL have these 2-bit output ports: ALUOp (to the ALU control stage; 00 = add, 01 = sub, 10 = funct decode), ALUSrcB and PCSource.
REQ-008 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-009 SHALL implement a Moore FSM with this encoding: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
REQ-010 SHALL use a single state register; all outputs are decoded combinationally from state, plus mem_ready where stated below.
REQ-011 SHALL drive every output to 0 in any state unless that output is listed for that state.
REQ-012 SHALL, in RST, drive all outputs to 0 and go to FETCH on the next edge.
REQ-013 SHALL, in FETCH, drive MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, with IRWrite=PCWrite=mem_ready; go to DECODE when mem_ready=1, otherwise hold.
REQ-014 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, and select the next state from Op:
 - 000000 -> EXEC
 - 100011 or 101011 -> MEMADR
 - 000100 -> BRANCH
 - 000010 -> JUMP
 - 001000 -> ADDIEX
 - any other opcode -> FETCH (illegal opcode treated as a NOP, no writes).
REQ-015 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMRD if Op=100011, otherwise MEMWR.
REQ-016 SHALL, in MEMRD, drive MemRead=1, IorD=1; go to MEMWB when mem_ready=1, otherwise hold.
REQ-017 SHALL, in MEMWB, drive RegWrite=1, MemtoReg=1, RegDst=0; go to FETCH.
REQ-018 SHALL, in MEMWR, drive MemWrite=1, IorD=1; go to FETCH when mem_ready=1, otherwise hold.
REQ-019 SHALL, in EXEC, drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB.
REQ-020 SHALL, in ALUWB, drive RegWrite=1, RegDst=1, MemtoReg=0; go to FETCH.
REQ-021 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; go to FETCH.
REQ-022 SHALL, in JUMP, drive PCWrite=1, PCSource=10; go to FETCH.
REQ-023 SHALL, in ADDIEX, drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ADDIWB.
REQ-024 SHALL, in ADDIWB, drive RegWrite=1, RegDst=0, MemtoReg=0; go to FETCH.
REQ-025 SHALL sample Op only in DECODE and MEMADR; changes to Op in other states have no effect.
REQ-026 SHALL have these instruction latencies from FETCH entry with mem_ready held at 1:
 - R-type: 4 cycles
 - lw: 5 cycles
 - sw: 4 cycles
 - beq: 3 cycles
 - j: 3 cycles
 - addi: 4 cycles
 Each memory wait cycle adds 1 cycle.
REQ-027 SHALL send unused encodings 13 to 15 to RST on the next edge.
REQ-028 SHALL never assert MemRead and MemWrite in the same cycle.

Reset
REQ-029 SHALL force state to RST immediately when reset is asserted, independent of clk, with all outputs 0 combinationally.
REQ-030 SHALL hold RST while reset is high; the first edge after deassertion enters FETCH.
REQ-031 SHALL abandon any operation in progress when reset is asserted mid-operation (including during a MEMWR wait), with no further write strobes.

Verification
REQ-032 SHALL cover: reset released, Op=000000, mem_ready=1 -> states 0,1,2,7,8,1; ALUOp=10 in EXEC; RegWrite=RegDst=1 in ALUWB.
REQ-033 SHALL cover: Op=100011, mem_ready low for 3 cycles in MEMRD -> state 4 held 4 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=1.
REQ-034 SHALL cover: Op=000100 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01 for exactly 1 cycle.
REQ-035 SHALL cover: Op=111111 (illegal) -> DECODE returns to FETCH; no RegWrite, MemWrite or PCWriteCond pulse occurs.
REQ-036 SHALL cover: reset asserted between edges during MEMWR -> state=0 and MemWrite=0 before the next clk edge.
REQ-037 SHALL cover: MEM_HANDSHAKE=0, mem_ready=0, Op=101011 -> sequence 1,2,3,6,1 with no stalls.
